uvma_mpb_txn_capture: RTL and testbench
=======================================

# uvma_mpb_txn_capture

Synthesizable capture stage that taps the same Matrix Peripheral Bus (MPB) signals the interface checker watches and converts each completed bus handshake into a transaction record with its handshake latency. Records are buffered in a small FIFO and offered downstream on a valid/ready port for scoreboards and emulation-side trackers. Timeout, abort and overflow conditions are reported as sticky flags.

## Interface

- DATA_WIDTH, 32, MPB data width
- ADDR_WIDTH, 32, MPB address width
- DEPTH, 4, record FIFO depth (power of 2, ≥2)
- TIMEOUT, 16, cycles of unanswered vld before timeout flag (≥1)
- clk  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mpb_vld  in  1  MPB request valid (tap)
- mpb_rdy  in  1  MPB target ready (tap)
- mpb_r_w  in  1  1 = write, 0 = read (tap)
- mpb_addr  in  ADDR_WIDTH  request address (tap)
- mpb_wdata  in  DATA_WIDTH  write data (tap)
- mpb_rdata  in  DATA_WIDTH  read data, valid in handshake cycle (tap)
- out_vld  out  1  record available
- out_rdy  in  1  downstream accepts record
- out_r_w  out  1  record direction
- out_addr  out  ADDR_WIDTH  record address
- out_data  out  DATA_WIDTH  wdata for writes, rdata for reads
- out_lat  out  8  handshake latency, saturating
- txn_count  out  16  handshakes seen, wrapping
- clr_flags  in  1  synchronous pulse clearing sticky flags
- overflow  out  1  sticky: record dropped on full FIFO
- timeout_err  out  1  sticky: vld outstanding ≥ TIMEOUT cycles
- abort_err  out  1  sticky: vld dropped before rdy

## Operation

- Handshake = cycle with mpb_vld & mpb_rdy; sample r_w, addr, wdata or rdata that cycle.
- FSM: IDLE, WAIT, STALL.
  - IDLE: vld&rdy → capture, lat=0, stay IDLE; vld&!rdy → WAIT, wait_cnt=1.
  - WAIT: vld&rdy → capture, lat=wait_cnt, → IDLE; vld&!rdy → wait_cnt++; when wait_cnt reaches TIMEOUT set timeout_err, → STALL; !vld → abort_err, → IDLE.
  - STALL: same as WAIT without further timeout action; handshake still captured.
- wait_cnt 8-bit saturating at 255; out_lat = saturated value.
- Back-to-back handshakes (vld&rdy consecutive cycles) each produce one record.
- Capture pushes to FIFO; full and no pop same cycle → record dropped, overflow set. Full with pop same cycle → push accepted.
- txn_count increments on every handshake (dropped included), 0xFFFF wraps to 0.
- clr_flags clears the three flags; a flag-setting event the same cycle wins (flag stays 1).
- Reset mid-transaction: FSM → IDLE, FIFO emptied, partial wait discarded.

## Timing

- Reset values: out_vld 0, out_r_w 0, out_addr 0, out_data 0, out_lat 0, txn_count 0, all flags 0, FSM IDLE.
- Handshake at cycle N → out_vld=1 at N+1 when FIFO empty (one-cycle latency); record held stable while out_vld & !out_rdy.
- Pop on out_vld & out_rdy; next record (if any) presented at the following cycle.
- Flags and txn_count update one cycle after the triggering event.
- Inputs sampled only on clk; no combinational path from MPB taps to outputs.

## Structure

- Package uvma_mpb_txn_capture_pkg: FSM state enum, LAT_W=8, CNT_W=16, packed record struct (r_w, addr, data, lat) parameterised via max widths.
- Sub-module uvma_mpb_txn_fifo: synchronous show-ahead FIFO, DEPTH entries, full/empty, simultaneous push/pop when full permitted.
- Top holds FSM, wait counter, txn counter, sticky flags.

## Test plan

- Write 0xA5A5_0001 to 0x10 with rdy same cycle → next cycle out_vld=1, out_r_w=1, out_addr=0x10, out_data=0xA5A5_0001, out_lat=0, txn_count=1.
- Read 0x20, rdy after 3 vld cycles, rdata 0xDEAD_BEEF → record out_lat=3, out_data=0xDEAD_BEEF, no flags.
- TIMEOUT=16, vld held 20 cycles then rdy → timeout_err=1 after cycle 16, record out_lat=20; clr_flags → 0.
- out_rdy=0, 5 back-to-back writes, DEPTH=4 → 4 records retained, overflow=1, txn_count=5; then out_rdy=1 drains 4 in order.
- vld 2 cycles then deasserted without rdy → abort_err=1, no record, txn_count unchanged; reset_n low mid-WAIT → all outputs at reset values.

Source files
------------

// File: rtl/uvma_mpb_txn_capture_pkg.sv
// Shared types for the MPB transaction capture stage: FSM states, counter widths, record layout.
package uvma_mpb_txn_capture_pkg;

  localparam int LAT_W  = 8;
  localparam int CNT_W  = 16;
  localparam int MAX_AW = 32;
  localparam int MAX_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STALL
  } state_t;

  // Sized for the widest supported bus; narrower instances zero-extend into it.
  typedef struct packed {
    logic              r_w;
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] data;
    logic [LAT_W-1:0]  lat;
  } rec_t;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uvma_mpb_txn_capture_if.sv
// MPB tap signals plus the downstream record port of the capture stage.
interface uvma_mpb_txn_capture_if
  import uvma_mpb_txn_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mpb_vld;
  logic                  mpb_rdy;
  logic                  mpb_r_w;
  logic [ADDR_WIDTH-1:0] mpb_addr;
  logic [DATA_WIDTH-1:0] mpb_wdata;
  logic [DATA_WIDTH-1:0] mpb_rdata;

  logic                  out_vld;
  logic                  out_rdy;
  logic                  out_r_w;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LAT_W-1:0]      out_lat;

  modport slave (
    input  mpb_vld, mpb_rdy, mpb_r_w, mpb_addr, mpb_wdata, mpb_rdata, out_rdy,
    output out_vld, out_r_w, out_addr, out_data, out_lat
  );

  modport master (
    output mpb_vld, mpb_rdy, mpb_r_w, mpb_addr, mpb_wdata, mpb_rdata, out_rdy,
    input  out_vld, out_r_w, out_addr, out_data, out_lat
  );
endinterface

// File: rtl/uvma_mpb_txn_fifo.sv
// Show-ahead FIFO: head entry visible on rd_dat whenever not empty.
// A push while full is accepted only if a pop happens in the same cycle.
module uvma_mpb_txn_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          pop_eff;
  logic          push_eff;

  assign full     = (cnt == (PW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign rd_dat   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/uvma_mpb_txn_capture.sv
// Turns each MPB vld&rdy handshake into a buffered record with its wait latency;
// records appear one cycle after the handshake, sticky flags report timeout/abort/drop.
module uvma_mpb_txn_capture
  import uvma_mpb_txn_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  uvma_mpb_txn_capture_if.slave bus,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] txn_count,
  output logic             overflow,
  output logic             timeout_err,
  output logic             abort_err
);
  localparam int TO_SAT = (TIMEOUT > 255) ? 255 : TIMEOUT;
  localparam logic [LAT_W-1:0] TO_CNT = LAT_W'(TO_SAT);

  state_t           state, state_nxt;
  logic [LAT_W-1:0] wait_cnt, wait_nxt;
  logic             cap;
  logic [LAT_W-1:0] cap_lat;
  logic             set_to;
  logic             set_ab;
  logic             set_ovf;

  rec_t             rec_in;
  rec_t             rec_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    cap       = 1'b0;
    cap_lat   = '0;
    set_to    = 1'b0;
    set_ab    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.mpb_vld) begin
          if (bus.mpb_rdy) begin
            cap = 1'b1;
          end else begin
            wait_nxt = LAT_W'(1);
            // A one-cycle timeout already expires on the first unanswered cycle.
            if (TO_CNT <= LAT_W'(1)) begin
              set_to    = 1'b1;
              state_nxt = ST_STALL;
            end else begin
              state_nxt = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT, ST_STALL: begin
        if (!bus.mpb_vld) begin
          set_ab    = 1'b1;
          wait_nxt  = '0;
          state_nxt = ST_IDLE;
        end else if (bus.mpb_rdy) begin
          cap       = 1'b1;
          cap_lat   = wait_cnt;
          wait_nxt  = '0;
          state_nxt = ST_IDLE;
        end else begin
          wait_nxt = sat_inc(wait_cnt);
          if (state == ST_WAIT && wait_nxt >= TO_CNT) begin
            set_to    = 1'b1;
            state_nxt = ST_STALL;
          end
        end
      end
      default: begin
        wait_nxt  = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    rec_in      = '0;
    rec_in.r_w  = bus.mpb_r_w;
    rec_in.addr = MAX_AW'(bus.mpb_addr);
    rec_in.data = bus.mpb_r_w ? MAX_DW'(bus.mpb_wdata) : MAX_DW'(bus.mpb_rdata);
    rec_in.lat  = cap_lat;
  end

  assign pop     = ~fifo_empty & bus.out_rdy;
  assign set_ovf = cap & fifo_full & ~pop;

  uvma_mpb_txn_fifo #(
    .W     ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (cap),
    .push_dat (rec_in),
    .pop      (pop),
    .rd_dat   (rec_q),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Gate the head entry so stale or uninitialised storage never leaks out.
  assign bus.out_vld  = ~fifo_empty;
  assign bus.out_r_w  = ~fifo_empty & rec_q.r_w;
  assign bus.out_addr = fifo_empty ? '0 : ADDR_WIDTH'(rec_q.addr);
  assign bus.out_data = fifo_empty ? '0 : DATA_WIDTH'(rec_q.data);
  assign bus.out_lat  = fifo_empty ? '0 : rec_q.lat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txn_count   <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      abort_err   <= 1'b0;
    end else begin
      if (cap) txn_count <= txn_count + 1'b1;
      overflow    <= (overflow    & ~clr_flags) | set_ovf;
      timeout_err <= (timeout_err & ~clr_flags) | set_to;
      abort_err   <= (abort_err   & ~clr_flags) | set_ab;
    end
  end
endmodule

// File: tb/tb_uvma_mpb_txn_capture.sv
// Directed self-checking bench for uvma_mpb_txn_capture with hand-computed expectations.
module tb_uvma_mpb_txn_capture;
  logic        clk;
  logic        reset_n;
  logic        clr_flags;
  logic [15:0] txn_count;
  logic        overflow;
  logic        timeout_err;
  logic        abort_err;

  int n_chk  = 0;
  int n_pass = 0;

  uvma_mpb_txn_capture_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  uvma_mpb_txn_capture #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (4),
    .TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .clr_flags   (clr_flags),
    .txn_count   (txn_count),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .abort_err   (abort_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic r, input logic rw,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    bus.mpb_vld   = v;
    bus.mpb_rdy   = r;
    bus.mpb_r_w   = rw;
    bus.mpb_addr  = a;
    bus.mpb_wdata = wd;
    bus.mpb_rdata = rd;
  endtask

  task automatic idle_bus();
    bus.mpb_vld = 1'b0;
    bus.mpb_rdy = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    clr_flags  = 1'b0;
    bus.out_rdy = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_out_vld",  bus.out_vld,  0);
    chk("rst_out_r_w",  bus.out_r_w,  0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_lat",  bus.out_lat,  0);
    chk("rst_txn",      txn_count,    0);
    chk("rst_flags",    {overflow, timeout_err, abort_err}, 0);
    reset_n = 1'b1;
    tick();

    // Zero-wait write.
    drive(1, 1, 1, 32'h10, 32'hA5A5_0001, 0);
    tick();
    idle_bus();
    chk("w0_vld",  bus.out_vld,  1);
    chk("w0_r_w",  bus.out_r_w,  1);
    chk("w0_addr", bus.out_addr, 32'h10);
    chk("w0_data", bus.out_data, 32'hA5A5_0001);
    chk("w0_lat",  bus.out_lat,  0);
    chk("w0_txn",  txn_count,    1);
    tick();
    chk("w0_hold_vld",  bus.out_vld,  1);
    chk("w0_hold_addr", bus.out_addr, 32'h10);
    bus.out_rdy = 1'b1;
    tick();
    bus.out_rdy = 1'b0;
    chk("w0_popped", bus.out_vld, 0);

    // Read answered after three wait cycles.
    drive(1, 0, 0, 32'h20, 0, 0);
    repeat (3) tick();
    bus.mpb_rdy   = 1'b1;
    bus.mpb_rdata = 32'hDEAD_BEEF;
    tick();
    idle_bus();
    chk("r3_vld",   bus.out_vld,  1);
    chk("r3_r_w",   bus.out_r_w,  0);
    chk("r3_addr",  bus.out_addr, 32'h20);
    chk("r3_data",  bus.out_data, 32'hDEAD_BEEF);
    chk("r3_lat",   bus.out_lat,  3);
    chk("r3_txn",   txn_count,    2);
    chk("r3_flags", {overflow, timeout_err, abort_err}, 0);
    bus.out_rdy = 1'b1;
    tick();
    bus.out_rdy = 1'b0;

    // Timeout after 16 unanswered cycles, handshake at 20.
    drive(1, 0, 1, 32'h30, 32'h1234_5678, 0);
    repeat (15) tick();
    chk("to_before", timeout_err, 0);
    tick();
    chk("to_set", timeout_err, 1);
    repeat (4) tick();
    bus.mpb_rdy = 1'b1;
    tick();
    idle_bus();
    chk("to_lat",  bus.out_lat,  20);
    chk("to_data", bus.out_data, 32'h1234_5678);
    chk("to_txn",  txn_count,    3);
    chk("to_held", timeout_err,  1);
    clr_flags   = 1'b1;
    bus.out_rdy = 1'b1;
    tick();
    clr_flags   = 1'b0;
    bus.out_rdy = 1'b0;
    chk("to_clr",    timeout_err, 0);
    chk("to_popped", bus.out_vld, 0);

    // Latency saturates at 255.
    drive(1, 0, 0, 32'h50, 0, 0);
    repeat (300) tick();
    bus.mpb_rdy   = 1'b1;
    bus.mpb_rdata = 32'h77;
    tick();
    idle_bus();
    chk("sat_lat",  bus.out_lat,  8'hFF);
    chk("sat_data", bus.out_data, 32'h77);
    chk("sat_to",   timeout_err,  1);
    chk("sat_txn",  txn_count,    4);
    clr_flags   = 1'b1;
    bus.out_rdy = 1'b1;
    tick();
    clr_flags   = 1'b0;
    bus.out_rdy = 1'b0;

    // Five back-to-back writes into a four-entry FIFO with no drain.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 32'h100 + i, 32'hB000_0000 + i, 0);
      tick();
    end
    idle_bus();
    chk("ovf_flag", overflow,    1);
    chk("ovf_txn",  txn_count,   9);
    chk("ovf_vld",  bus.out_vld, 1);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_drain_addr%0d", i), bus.out_addr, 32'h100 + i);
      chk($sformatf("ovf_drain_data%0d", i), bus.out_data, 32'hB000_0000 + i);
      tick();
    end
    bus.out_rdy = 1'b0;
    chk("ovf_empty", bus.out_vld, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;

    // Push into a full FIFO with a simultaneous pop is accepted.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 32'h200 + i, 32'hC000_0000 + i, 0);
      tick();
    end
    drive(1, 1, 1, 32'h204, 32'hC000_0004, 0);
    bus.out_rdy = 1'b1;
    tick();
    idle_bus();
    bus.out_rdy = 1'b0;
    chk("fp_no_ovf", overflow,     0);
    chk("fp_head",   bus.out_addr, 32'h201);
    chk("fp_txn",    txn_count,    14);
    bus.out_rdy = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("fp_drain_addr%0d", i), bus.out_addr, 32'h200 + i);
      tick();
    end
    bus.out_rdy = 1'b0;
    chk("fp_empty", bus.out_vld, 0);

    // Abort, with clr_flags in the same cycle: the set wins.
    drive(1, 0, 0, 32'h40, 0, 0);
    repeat (2) tick();
    idle_bus();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ab_flag", abort_err,   1);
    chk("ab_norec", bus.out_vld, 0);
    chk("ab_txn",  txn_count,   14);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ab_clr", abort_err, 0);

    // Reset while a record is buffered and a wait is in progress.
    drive(1, 1, 1, 32'h60, 32'hCAFE_0060, 0);
    tick();
    chk("mr_rec_vld", bus.out_vld, 1);
    drive(1, 0, 0, 32'h70, 0, 0);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    chk("mr_vld",   bus.out_vld,  0);
    chk("mr_r_w",   bus.out_r_w,  0);
    chk("mr_addr",  bus.out_addr, 0);
    chk("mr_data",  bus.out_data, 0);
    chk("mr_lat",   bus.out_lat,  0);
    chk("mr_txn",   txn_count,    0);
    chk("mr_flags", {overflow, timeout_err, abort_err}, 0);
    reset_n = 1'b1;
    tick();
    bus.mpb_rdy   = 1'b1;
    bus.mpb_rdata = 32'h99;
    tick();
    idle_bus();
    chk("pr_vld",  bus.out_vld,  1);
    chk("pr_addr", bus.out_addr, 32'h70);
    chk("pr_data", bus.out_data, 32'h99);
    chk("pr_lat",  bus.out_lat,  1);
    chk("pr_txn",  txn_count,    1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
